// File: rtl/hazard_scheduler.sv
// hazard_scheduler: 3-entry scoreboard hazard unit (stall/bubble/flush/forward) with halt drain.
// Define FORWARD_EN for EX/MEM operand forwarding; otherwise any EX/MEM RAW match interlocks.
module hazard_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [3:0] id_readReg0,
    input  logic [3:0] id_readReg1,
    input  logic       id_use0,
    input  logic       id_use1,
    input  logic       id_write,
    input  logic [3:0] id_write_reg,
    input  logic       id_MemtoReg,
    input  logic       id_start,
    input  logic       ex_branch_taken,
    output logic       stall,
    output logic       bubble,
    output logic       flush,
    output logic       halted,
    output logic [1:0] fwd0,
    output logic [1:0] fwd1
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       load;
    } sb_entry_t;

    state_e    state_q;
    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;
    logic      halted_q;

    logic ex_m0, ex_m1, mem_m0, mem_m1;
    logic hazard;
    logic accept;
    logic sb_empty;

    // WB is never compared: the register file writes before it is read.
    assign ex_m0  = id_use0 && ex_q.valid  && (id_readReg0 == ex_q.rd);
    assign ex_m1  = id_use1 && ex_q.valid  && (id_readReg1 == ex_q.rd);
    assign mem_m0 = id_use0 && mem_q.valid && (id_readReg0 == mem_q.rd);
    assign mem_m1 = id_use1 && mem_q.valid && (id_readReg1 == mem_q.rd);

`ifdef FORWARD_EN
    assign hazard = (ex_m0 || ex_m1) && ex_q.load;

    // Youngest producer wins; a load in EX cannot forward and is covered by the stall.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_load,
                                           input logic mem_m);
        if (ex_m && !ex_load) return 2'b01;
        else if (mem_m)       return 2'b10;
        else                  return 2'b00;
    endfunction
`else
    assign hazard = ex_m0 || ex_m1 || mem_m0 || mem_m1;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        fwd0   = 2'b00;
        fwd1   = 2'b00;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush = 1'b1;
                    end else if (id_valid) begin
                        stall  = hazard;
                        bubble = hazard;
`ifdef FORWARD_EN
                        fwd0 = fwd_sel(ex_m0, ex_q.load, mem_m0);
                        fwd1 = fwd_sel(ex_m1, ex_q.load, mem_m1);
`endif
                    end
                end
                DRAIN, HALTED: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign accept   = id_valid && !stall && !flush && (state_q == RUN);
    assign sb_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid;
    assign halted   = halted_q;

    always_comb begin
        ex_d = '0;
        if (accept && id_write) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_write_reg;
            ex_d.load  = id_MemtoReg;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            unique case (state_q)
                RUN: begin
                    if (accept && id_start) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (sb_empty) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: ;
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler; expectations follow the FORWARD_EN build setting.
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_readReg0, id_readReg1;
    logic       id_use0, id_use1;
    logic       id_write;
    logic [3:0] id_write_reg;
    logic       id_MemtoReg;
    logic       id_start;
    logic       ex_branch_taken;
    logic       stall, bubble, flush, halted;
    logic [1:0] fwd0, fwd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_readReg0     (id_readReg0),
        .id_readReg1     (id_readReg1),
        .id_use0         (id_use0),
        .id_use1         (id_use1),
        .id_write        (id_write),
        .id_write_reg    (id_write_reg),
        .id_MemtoReg     (id_MemtoReg),
        .id_start        (id_start),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .bubble          (bubble),
        .flush           (flush),
        .halted          (halted),
        .fwd0            (fwd0),
        .fwd1            (fwd1)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic s, input logic b, input logic f);
        check({tag, ".stall"}, stall, s);
        check({tag, ".bubble"}, bubble, b);
        check({tag, ".flush"}, flush, f);
    endtask

    task automatic idle();
        id_valid        = 1'b0;
        id_readReg0     = 4'd0;
        id_readReg1     = 4'd0;
        id_use0         = 1'b0;
        id_use1         = 1'b0;
        id_write        = 1'b0;
        id_write_reg    = 4'd0;
        id_MemtoReg     = 1'b0;
        id_start        = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic instr(input logic [3:0] r0, input logic u0, input logic [3:0] r1,
                         input logic u1, input logic w, input logic [3:0] wr,
                         input logic ld, input logic st);
        id_valid     = 1'b1;
        id_readReg0  = r0;
        id_use0      = u0;
        id_readReg1  = r1;
        id_use1      = u1;
        id_write     = w;
        id_write_reg = wr;
        id_MemtoReg  = ld;
        id_start     = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the current ID instruction retire into EX, then empty the scoreboard.
    task automatic gap();
        tick();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        instr(4'd1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        ctl("reset_outputs", 1'b0, 1'b0, 1'b0);
        check("reset_fwd0", fwd0, 2'b00);
        check("reset_halted", halted, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        ctl("post_reset", 1'b0, 1'b0, 1'b0);
        check("post_reset_halted", halted, 1'b0);
        check("post_reset_fwd1", fwd1, 2'b00);

        // (a) load r2 followed by a use of r2
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        #1 ctl("a_load", 1'b0, 1'b0, 1'b0);
        tick();
        instr(4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        #1 ctl("a_use_c1", 1'b1, 1'b1, 1'b0);
        tick();
`ifdef FORWARD_EN
        #1 ctl("a_use_c2", 1'b0, 1'b0, 1'b0);
        check("a_fwd0", fwd0, 2'b10);
`else
        #1 ctl("a_use_c2", 1'b1, 1'b1, 1'b0);
        tick();
        #1 ctl("a_use_c3", 1'b0, 1'b0, 1'b0);
        check("a_fwd0", fwd0, 2'b00);
`endif
        gap();

        // (b) add r3 then immediate use of r3
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        instr(4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd11, 1'b0, 1'b0);
`ifdef FORWARD_EN
        #1 ctl("b_adj", 1'b0, 1'b0, 1'b0);
        check("b_adj_fwd0", fwd0, 2'b01);
`else
        #1 ctl("b_adj_c1", 1'b1, 1'b1, 1'b0);
        tick();
        #1 ctl("b_adj_c2", 1'b1, 1'b1, 1'b0);
        tick();
        #1 ctl("b_adj_c3", 1'b0, 1'b0, 1'b0);
`endif
        gap();

        // (b) add r3, unrelated r4, then use of r3 on source 1
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        #1 ctl("b_mid", 1'b0, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0);
`ifdef FORWARD_EN
        #1 ctl("b_gap", 1'b0, 1'b0, 1'b0);
        check("b_gap_fwd1", fwd1, 2'b10);
`else
        #1 ctl("b_gap_c1", 1'b1, 1'b1, 1'b0);
        tick();
        #1 ctl("b_gap_c2", 1'b0, 1'b0, 1'b0);
`endif
        gap();

        // (c) add r1 then both sources read r1
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        instr(4'd1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
`ifdef FORWARD_EN
        #1 ctl("c_both", 1'b0, 1'b0, 1'b0);
        check("c_fwd0", fwd0, 2'b01);
        check("c_fwd1", fwd1, 2'b01);
`else
        #1 ctl("c_both", 1'b1, 1'b1, 1'b0);
        check("c_fwd0", fwd0, 2'b00);
        check("c_fwd1", fwd1, 2'b00);
`endif
        gap();

        // two producers of r1 in EX and MEM: the younger (EX) one is selected
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        instr(4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
`ifdef FORWARD_EN
        #1 ctl("young", 1'b0, 1'b0, 1'b0);
        check("young_fwd0", fwd0, 2'b01);
`else
        #1 ctl("young", 1'b1, 1'b1, 1'b0);
`endif
        gap();

        // producer only in WB, and an unused source naming the EX register
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd14, 1'b1, 1'b0);
        tick();
        instr(4'd6, 1'b1, 4'd14, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        #1 ctl("wb_nomatch", 1'b0, 1'b0, 1'b0);
        check("wb_fwd0", fwd0, 2'b00);
        check("wb_fwd1", fwd1, 2'b00);
        gap();

        // (d) branch taken while ID holds a load-use; flushed load r7 must not enter EX
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        tick();
        instr(4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1 ctl("d_flush", 1'b0, 1'b0, 1'b1);
        tick();
        ex_branch_taken = 1'b0;
        instr(4'd7, 1'b1, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        #1 ctl("d_ex_invalid", 1'b0, 1'b0, 1'b0);
        check("d_fwd0", fwd0, 2'b00);
        gap();

        // (e) halt behind a full scoreboard: 3 DRAIN cycles then HALTED
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1 ctl("e_halt_accept", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        ex_branch_taken = 1'b1;
        #1 ctl("e_drain1", 1'b1, 1'b1, 1'b0);
        check("e_drain1_halted", halted, 1'b0);
        tick();
        ex_branch_taken = 1'b0;
        #1 ctl("e_drain2", 1'b1, 1'b1, 1'b0);
        tick();
        #1 ctl("e_drain3", 1'b1, 1'b1, 1'b0);
        check("e_drain3_halted", halted, 1'b0);
        tick();
        #1 ctl("e_halted", 1'b1, 1'b1, 1'b0);
        check("e_halted_flag", halted, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            ex_branch_taken = i[0];
            id_valid        = i[1];
            #1;
            check($sformatf("e_hold%0d_halted", i), halted, 1'b1);
            ctl($sformatf("e_hold%0d", i), 1'b1, 1'b1, 1'b0);
        end

        // (f) reset while HALTED
        idle();
        reset = 1'b1;
        #1 ctl("f_rst_halted_out", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1 ctl("f_after_halted", 1'b0, 1'b0, 1'b0);
        check("f_after_halted_flag", halted, 1'b0);
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        #1 ctl("f_run_accept", 1'b0, 1'b0, 1'b0);
        gap();

        // (e) halt coincident with a taken branch is squashed
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        ex_branch_taken = 1'b1;
        #1 ctl("e_halt_branch", 1'b0, 1'b0, 1'b1);
        tick();
        ex_branch_taken = 1'b0;
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        #1 ctl("e_still_run", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1 ctl("e_still_run2", 1'b0, 1'b0, 1'b0);
        check("e_still_run_halted", halted, 1'b0);
        gap();

        // (f) reset during DRAIN
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        idle();
        #1 ctl("f_in_drain", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1 ctl("f_rst_drain_out", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1 ctl("f_after_drain", 1'b0, 1'b0, 1'b0);
        check("f_after_drain_halted", halted, 1'b0);

        // halt with an empty scoreboard: one DRAIN cycle, then HALTED
        instr(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1 ctl("f_halt2_accept", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1 ctl("f_drain_short", 1'b1, 1'b1, 1'b0);
        check("f_drain_short_halted", halted, 1'b0);
        tick();
        #1 check("f_halted2", halted, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
